debouncer_bank: RTL and testbench
=================================

DEBOUNCER_BANK -- requirements
Module: debouncer_bank

Interface
REQ-001 Parameter N_CH, default 4: number of independent switch channels, range 1..32.
REQ-002 Parameter DELAY_CNT, default 1500000: stable cycles required to accept a level change (30 ms at 50 MHz), minimum 2.
REQ-003 Parameter ACTIVE_LVL, default 1'b1: raw level meaning "pressed".
REQ-004 Parameter LONG_CNT, default 50000000: cycles held before a long-press pulse; used only when DEBOUNCER_LONG_PRESS_EN is defined; must exceed DELAY_CNT.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 nrst  input  1  asynchronous, active-low reset.
REQ-007 sw  input  N_CH  raw asynchronous switch inputs, one bit per channel.
REQ-008 level  output  N_CH  debounced state per channel, 1 = pressed.
REQ-009 press_pulse  output  N_CH  one-cycle pulse on accepted press.
REQ-010 release_pulse  output  N_CH  one-cycle pulse on accepted release.
REQ-011 long_pulse  output  N_CH  one-cycle pulse on long press; tied 0 when feature is compiled out.

Function
REQ-012 Each sw bit shall pass through a 2-flop synchronizer, normalised by ACTIVE_LVL so that 1 = pressed (sync_p).
REQ-013 Each channel shall run an independent FSM with states IDLE, DB_PRESS, PRESSED, DB_RELEASE, plus a counter of width $clog2(max(DELAY_CNT,LONG_CNT)).
REQ-014 IDLE: sync_p=1 -> DB_PRESS with counter cleared to 0; otherwise remain in IDLE.
REQ-015 DB_PRESS: sync_p=0 -> IDLE and counter cleared; sync_p=1 and counter=DELAY_CNT-1 -> PRESSED; otherwise counter increments.
REQ-016 PRESSED: sync_p=0 -> DB_RELEASE with counter cleared; otherwise remain.
REQ-017 DB_RELEASE: sync_p=1 -> PRESSED; sync_p=0 and counter=DELAY_CNT-1 -> IDLE; otherwise counter increments.
REQ-018 press_pulse is registered and high exactly in the first cycle the FSM is in PRESSED after coming from DB_PRESS; it is not asserted on DB_RELEASE->PRESSED.
REQ-019 release_pulse is high exactly in the first cycle the FSM is in IDLE after coming from DB_RELEASE.
REQ-020 level = 1 in PRESSED and DB_RELEASE, 0 in IDLE and DB_PRESS.
REQ-021 Latency: a clean press held steady produces press_pulse DELAY_CNT+3 cycles after the sw edge is sampled (2 synchronizer cycles + 1 entry cycle + DELAY_CNT).
REQ-022 A glitch shorter than DELAY_CNT cycles after synchronisation shall produce no pulse and no level change.
REQ-023 Channels shall be fully independent: simultaneous events on any subset of channels produce their pulses in the same cycle.
REQ-024 The counter shall never wrap; it saturates at its terminal value.

Reset
REQ-025 nrst low shall asynchronously force all synchronizer flops to the released level, all FSMs to IDLE, all counters to 0, and all outputs to 0.
REQ-026 Reset asserted mid-debounce or mid-press shall discard the event; no pulse is emitted on reset release, even if sw is held pressed. A held switch instead re-debounces from IDLE.

Configuration
REQ-027 With macro DEBOUNCER_LONG_PRESS_EN defined, the counter shall keep counting in PRESSED, and long_pulse shall fire once per press when the PRESSED dwell reaches LONG_CNT cycles; the counter then saturates.
REQ-028 Without DEBOUNCER_LONG_PRESS_EN, long_pulse shall be constant 0 and no long-press logic shall be synthesised.

Structure
REQ-029 Package debouncer_pkg shall hold the FSM state enum typedef (2-bit) and the default DELAY_CNT/LONG_CNT constants.
REQ-030 Per-channel synchronizer, FSM and counter shall live in sub-module debounce_channel, instantiated N_CH times via generate; the top level only slices the buses.

Verification (N_CH=4, DELAY_CNT=10, LONG_CNT=40, ACTIVE_LVL=1)
REQ-031 Scenario: sw[0] rises and is held -> press_pulse[0] high for exactly 1 cycle, 13 cycles after the sampled edge; level[0]=1 from that cycle.
REQ-032 Scenario: sw[1] pulsed high for 6 cycles -> no press_pulse, level[1] stays 0.
REQ-033 Scenario: held press, then sw[0] low for 5 cycles, then high again -> no release_pulse, no second press_pulse, level[0] stays 1.
REQ-034 Scenario: sw[3:0]=4'b1111 in the same cycle -> press_pulse=4'b1111 in one cycle; a later release gives release_pulse=4'b1111 13 cycles after the sampled release edge.
REQ-035 Scenario: nrst pulsed low 5 cycles after a press edge, sw held -> all outputs 0 immediately; press_pulse occurs 13 cycles after nrst deasserts.
REQ-036 Scenario (DEBOUNCER_LONG_PRESS_EN defined): sw[2] held 100 cycles -> exactly one long_pulse[2], 40 cycles after press_pulse[2]; with the macro undefined, long_pulse stays 0.

Source files
------------

// File: rtl/debouncer_pkg.sv
// Shared types and defaults for the switch debouncer bank.
// Optional long-press detection is enabled with macro DEBOUNCER_LONG_PRESS_EN.
package debouncer_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DB_PRESS   = 2'd1,
      PRESSED    = 2'd2,
      DB_RELEASE = 2'd3
   } state_t;

   localparam int DEF_DELAY_CNT = 1500000;
   localparam int DEF_LONG_CNT  = 50000000;

   // Counter must hold the larger of the two terminal values.
   function automatic int cnt_width(input int delay_cnt, input int long_cnt);
      int m;
      m = (delay_cnt > long_cnt) ? delay_cnt : long_cnt;
      return (m > 2) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchronizer, debounce FSM, pulse outputs.
// Long-press pulse logic exists only when DEBOUNCER_LONG_PRESS_EN is defined.
module debounce_channel
   import debouncer_pkg::*;
#(
   parameter int   DELAY_CNT  = DEF_DELAY_CNT,
   parameter int   LONG_CNT   = DEF_LONG_CNT,
   parameter logic ACTIVE_LVL = 1'b1
) (
   input  logic clk,
   input  logic nrst,
   input  logic sw,
   output logic level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse
);

   localparam int CNT_W = cnt_width(DELAY_CNT, LONG_CNT);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DELAY_CNT - 1);

   logic             sync1;
   logic             sync2;
   logic             sync_p;
   state_t           state;
   logic [CNT_W-1:0] cnt;

   assign sync_p = (sync2 == ACTIVE_LVL);

`ifdef DEBOUNCER_LONG_PRESS_EN
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
   logic long_done;
`else
   assign long_pulse = 1'b0;
`endif

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sync1         <= ~ACTIVE_LVL;
         sync2         <= ~ACTIVE_LVL;
         state         <= IDLE;
         cnt           <= '0;
         level         <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
`ifdef DEBOUNCER_LONG_PRESS_EN
         long_pulse    <= 1'b0;
         long_done     <= 1'b0;
`endif
      end else begin
         sync1         <= sw;
         sync2         <= sync1;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
`ifdef DEBOUNCER_LONG_PRESS_EN
         long_pulse    <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (sync_p) begin
                  state <= DB_PRESS;
                  cnt   <= '0;
               end
            end
            DB_PRESS: begin
               if (!sync_p) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == DB_LAST) begin
                  state       <= PRESSED;
                  level       <= 1'b1;
                  press_pulse <= 1'b1;
                  cnt         <= '0;
`ifdef DEBOUNCER_LONG_PRESS_EN
                  long_done   <= 1'b0;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PRESSED: begin
               if (!sync_p) begin
                  state <= DB_RELEASE;
                  cnt   <= '0;
               end
`ifdef DEBOUNCER_LONG_PRESS_EN
               // Dwell counter stops at its terminal value once the pulse has fired.
               else if (!long_done) begin
                  if (cnt == LONG_LAST) begin
                     long_pulse <= 1'b1;
                     long_done  <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
`endif
            end
            DB_RELEASE: begin
               if (sync_p) begin
                  state <= PRESSED;
                  cnt   <= '0;
               end else if (cnt == DB_LAST) begin
                  state         <= IDLE;
                  level         <= 1'b0;
                  release_pulse <= 1'b1;
                  cnt           <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/debouncer_bank.sv
// Bank of N_CH independent switch debouncers; the top only slices the buses.
// Long-press pulses are enabled with macro DEBOUNCER_LONG_PRESS_EN.
module debouncer_bank
   import debouncer_pkg::*;
#(
   parameter int   N_CH       = 4,
   parameter int   DELAY_CNT  = DEF_DELAY_CNT,
   parameter logic ACTIVE_LVL = 1'b1,
   parameter int   LONG_CNT   = DEF_LONG_CNT
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic [N_CH-1:0] sw,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] press_pulse,
   output logic [N_CH-1:0] release_pulse,
   output logic [N_CH-1:0] long_pulse
);

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         debounce_channel #(
            .DELAY_CNT  (DELAY_CNT),
            .LONG_CNT   (LONG_CNT),
            .ACTIVE_LVL (ACTIVE_LVL)
         ) u_ch (
            .clk           (clk),
            .nrst          (nrst),
            .sw            (sw[gi]),
            .level         (level[gi]),
            .press_pulse   (press_pulse[gi]),
            .release_pulse (release_pulse[gi]),
            .long_pulse    (long_pulse[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_debouncer_bank.sv
// Self-checking bench for debouncer_bank: directed scenarios plus random toggling
// checked against a run-length reference model. Honours DEBOUNCER_LONG_PRESS_EN.
module tb_debouncer_bank;

   localparam int N = 4;
   localparam int D = 10;
   localparam int L = 40;

   logic         clk = 1'b0;
   logic         nrst = 1'b0;
   logic [N-1:0] sw = '0;
   logic [N-1:0] level, press_pulse, release_pulse, long_pulse;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc_no   = 0;

   // Reference model: level flips after D+1 consecutive synchronized samples disagree with it.
   int           m_s1 [N];
   int           m_s2 [N];
   int           m_lvl [N];
   int           m_run [N];
   int           m_dwell [N];
   int           m_ldone [N];
   logic [N-1:0] e_level, e_press, e_release, e_long;

   debouncer_bank #(
      .N_CH       (N),
      .DELAY_CNT  (D),
      .ACTIVE_LVL (1'b1),
      .LONG_CNT   (L)
   ) dut (
      .clk           (clk),
      .nrst          (nrst),
      .sw            (sw),
      .level         (level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc_no);
   endtask

   task automatic model_reset();
      for (int c = 0; c < N; c++) begin
         m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_run[c] = 0;
         m_dwell[c] = 0; m_ldone[c] = 0;
      end
      e_level = '0; e_press = '0; e_release = '0; e_long = '0;
   endtask

   task automatic model_edge();
      int sp;
      if (!nrst) begin
         model_reset();
         return;
      end
      e_press = '0; e_release = '0; e_long = '0;
      for (int c = 0; c < N; c++) begin
         sp = m_s2[c];
         if (m_lvl[c] == 1 && m_run[c] == 0 && sp == 1 && m_ldone[c] == 0) begin
            m_dwell[c]++;
            if (m_dwell[c] == L) begin
               e_long[c]  = 1'b1;
               m_ldone[c] = 1;
            end
         end
         if (m_lvl[c] == 1 && sp == 0) m_dwell[c] = 0;
         if (sp != m_lvl[c]) m_run[c]++;
         else m_run[c] = 0;
         if (m_run[c] == D + 1) begin
            m_lvl[c] = sp;
            m_run[c] = 0;
            if (sp == 1) begin
               e_press[c] = 1'b1; m_dwell[c] = 0; m_ldone[c] = 0;
            end else begin
               e_release[c] = 1'b1;
            end
         end
         e_level[c] = (m_lvl[c] != 0);
         m_s2[c] = m_s1[c];
         m_s1[c] = int'(sw[c]);
      end
   endtask

   // One clock: advance model on the edge, compare all outputs 1 time unit later.
   task automatic cyc();
      @(posedge clk);
      model_edge();
      cyc_no++;
      #1;
      chk("level", level, e_level);
      chk("press_pulse", press_pulse, e_press);
      chk("release_pulse", release_pulse, e_release);
`ifdef DEBOUNCER_LONG_PRESS_EN
      chk("long_pulse", long_pulse, e_long);
`else
      chk("long_pulse", long_pulse, '0);
`endif
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      model_reset();
      #1;
      chk("rst_async_zero", {level, press_pulse, release_pulse, long_pulse}, '0);
   endtask

   initial begin
      int saw;
      int p_cyc;
      int l_cyc;
      int n_long;
      int hold [N];

      model_reset();
      // Reset state
      for (int k = 0; k < 3; k++) cyc();
      chk("reset_outputs", {level, press_pulse, release_pulse, long_pulse}, '0);
      nrst = 1'b1;
      for (int k = 0; k < 2; k++) cyc();

      // Clean press: pulse on the 13th edge after sw changes
      sw[0] = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         cyc();
         chk("s1_press_lat", press_pulse[0], (k == D + 3));
         chk("s1_level", level[0], (k >= D + 3));
      end

      // Short glitch on channel 1
      sw[1] = 1'b1;
      saw = 0;
      for (int k = 0; k < 6; k++) begin cyc(); saw |= int'(press_pulse[1]); end
      sw[1] = 1'b0;
      for (int k = 0; k < 20; k++) begin cyc(); saw |= int'(press_pulse[1] | level[1]); end
      chk("s2_glitch_none", saw, 0);

      // Release glitch while held
      sw[0] = 1'b0;
      saw = 0;
      for (int k = 0; k < 5; k++) begin cyc(); saw |= int'(release_pulse[0]); end
      sw[0] = 1'b1;
      for (int k = 0; k < 20; k++) begin cyc(); saw |= int'(release_pulse[0] | press_pulse[0]); end
      chk("s3_no_pulse", saw, 0);
      chk("s3_level_held", level[0], 1);

      sw[0] = 1'b0;
      for (int k = 0; k < 16; k++) cyc();

      // All channels together, press then release
      sw = 4'b1111;
      for (int k = 1; k <= D + 3; k++) cyc();
      chk("s4_press_all", press_pulse, 4'b1111);
      for (int k = 0; k < 5; k++) cyc();
      sw = 4'b0000;
      for (int k = 1; k <= D + 3; k++) begin
         cyc();
         chk("s4_release_all", release_pulse, (k == D + 3) ? 4'b1111 : 4'b0000);
      end
      for (int k = 0; k < 3; k++) cyc();

      // Reset mid-debounce with switch held
      sw[0] = 1'b1;
      for (int k = 0; k < 5; k++) cyc();
      #2;
      do_reset();
      for (int k = 0; k < 2; k++) cyc();
      nrst = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         cyc();
         chk("s5_press_after_rst", press_pulse[0], (k == D + 3));
      end
      sw[0] = 1'b0;
      for (int k = 0; k < 16; k++) cyc();

      // Long hold on channel 2
      sw[2] = 1'b1;
      p_cyc = -1; l_cyc = -1; n_long = 0;
      for (int k = 0; k < 100; k++) begin
         cyc();
         if (press_pulse[2]) p_cyc = cyc_no;
         if (long_pulse[2]) begin l_cyc = cyc_no; n_long++; end
      end
      chk("s6_press_seen", (p_cyc >= 0), 1);
`ifdef DEBOUNCER_LONG_PRESS_EN
      chk("s6_long_count", n_long, 1);
      chk("s6_long_delay", l_cyc - p_cyc, L);
`else
      chk("s6_long_count", n_long, 0);
`endif
      sw[2] = 1'b0;
      for (int k = 0; k < 16; k++) cyc();

      // Randomized toggling with occasional reset
      for (int c = 0; c < N; c++) hold[c] = $urandom_range(1, 50);
      for (int k = 0; k < 1500; k++) begin
         for (int c = 0; c < N; c++) begin
            hold[c]--;
            if (hold[c] <= 0) begin
               sw[c] = ~sw[c];
               hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 70) : $urandom_range(1, 16);
            end
         end
         if ($urandom_range(0, 399) == 0) begin
            do_reset();
            cyc();
            nrst = 1'b1;
         end
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
